am_search_hf: RTL and testbench
===============================

Name: am_search_hf

Overview:
Associative-memory search stage directly downstream of the bundler. Takes the bundled query hypervector and computes the Hamming distance to each stored class prototype (interictal, ictal, ...), processing CHUNK_BITS bits per cycle. Reports the nearest class and its distance with a one-cycle done pulse, which drives the seizure/non-seizure decision.

Parameters:
DIMENSIONS, 10000, hypervector width in bits.
NUM_CLASSES, 2, number of class prototypes.
CHUNK_BITS, 100, bits compared per cycle; NUM_CHUNKS = ceil(DIMENSIONS/CHUNK_BITS).
DIST_W (localparam), $clog2(DIMENSIONS+1), distance width.
CLASS_W (localparam), max(1,$clog2(NUM_CLASSES)), class index width.

Ports:
clk  input  1  clock; all state updates on rising edge.
nrst  input  1  asynchronous active-low reset.
en  input  1  start strobe; connected to the bundler's out pulse.
hv_in  input  DIMENSIONS  query HV; connected to the bundler's hv_out; sampled only on an accepted en.
class_hvs  input  [NUM_CLASSES-1:0][DIMENSIONS-1:0]  prototypes; must be stable while busy=1.
busy  output  1  high from the cycle after an accepted en until the out pulse, inclusive.
out  output  1  one-cycle done pulse.
class_out  output  CLASS_W  index of the nearest class; held until the next done.
min_dist  output  DIST_W  Hamming distance to class_out; held until the next done.

Behaviour:
- Reset (nrst=0, asynchronous): FSM to IDLE. busy=0, out=0, class_out=0, min_dist=0. Query register, chunk counter and all accumulators cleared.
- States: IDLE, COMPARE, DONE.
- IDLE:
  - en=1 at an edge latches hv_in into the query register.
  - Chunk counter set to 0 and all NUM_CLASSES accumulators set to 0.
  - Transition to COMPARE.
- COMPARE:
  - Each cycle, chunk k (bits k*CHUNK_BITS upward) is XORed with the same bits of each prototype.
  - The popcount is added to that class's accumulator.
  - Last chunk: bit positions >= DIMENSIONS are masked to 0 and never counted.
  - After chunk NUM_CHUNKS-1 is accumulated, transition to DONE.
- DONE (one cycle):
  - Argmin over the accumulators; ties resolve to the lowest class index.
  - class_out and min_dist registered; out=1 for this cycle only; return to IDLE.
- Latency: en sampled at edge 0 -> out=1 and results valid after edge NUM_CHUNKS+1; busy is high over the same span.
- Back-to-back: en may be accepted in the cycle right after out; minimum spacing between accepted requests is NUM_CHUNKS+2 cycles.
- en while busy=1: ignored. The query register and accumulators are untouched.
- Accumulators are DIST_W wide and cannot overflow (max = DIMENSIONS).
- class_out/min_dist change only on a DONE cycle or on reset.
- Reset asserted mid-COMPARE: aborts immediately, no out pulse, outputs return to reset values.

Optional Feature:
Macro AM_OVERRUN_ERR_EN.
- Defined: adds output port err (1 bit, reset 0). err is set sticky when en=1 arrives while busy=1 (a dropped bundler result) and is cleared only by nrst. Search behaviour is unchanged.
- Undefined: no err port and no overrun logic.

Test Plan:
All scenarios use DIMENSIONS=10, CHUNK_BITS=4, NUM_CLASSES=2 (3 chunks, last chunk partial); class_hvs[0]=10'h000, class_hvs[1]=10'h3FF unless stated.
1. Basic: en pulse, hv_in=10'h007 -> out high exactly at edge 4 after en; class_out=0, min_dist=3; busy high edges 1-4.
2. Opposite class: hv_in=10'h3F0 -> class_out=1, min_dist=4.
3. Tie: hv_in=10'h01F -> distances 5/5 -> class_out=0, min_dist=5.
4. Partial-chunk masking: class_hvs[1]=10'h200, hv_in=10'h200 -> dist1=0, class_out=1, min_dist=0.
5. Busy ignore: en with hv_in=10'h007, then en with hv_in=10'h3FF two cycles later -> result class_out=0, min_dist=3, single out pulse; with AM_OVERRUN_ERR_EN, err=1 and stays 1 until nrst.
6. Reset mid-op: en with 10'h3F0, nrst low during the 2nd COMPARE cycle -> no out pulse, busy=0, class_out=0, min_dist=0. After release, en with 10'h3F0 -> class_out=1, min_dist=4 at latency 4.

Source files
------------

// File: rtl/am_search_hf.sv
// Associative-memory search: chunked Hamming distance from the query HV to each class
// prototype, then argmin. Define AM_OVERRUN_ERR_EN to add the sticky overrun flag `err`.
module am_search_hf #(
  parameter  int DIMENSIONS  = 10000,
  parameter  int NUM_CLASSES = 2,
  parameter  int CHUNK_BITS  = 100,
  localparam int DIST_W      = $clog2(DIMENSIONS + 1),
  localparam int CLASS_W     = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                                    clk,
  input  logic                                    nrst,
  input  logic                                    en,
  input  logic [DIMENSIONS-1:0]                   hv_in,
  input  logic [NUM_CLASSES-1:0][DIMENSIONS-1:0]  class_hvs,
  output logic                                    busy,
  output logic                                    out,
  output logic [CLASS_W-1:0]                      class_out,
  output logic [DIST_W-1:0]                       min_dist
`ifdef AM_OVERRUN_ERR_EN
  ,
  output logic                                    err
`endif
);

  localparam int NUM_CHUNKS = (DIMENSIONS + CHUNK_BITS - 1) / CHUNK_BITS;
  localparam int PAD_W      = NUM_CHUNKS * CHUNK_BITS;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    DONE
  } state_t;

  state_t                          state, state_next;
  logic [DIMENSIONS-1:0]           query;
  logic [CNT_W-1:0]                chunk_cnt;
  logic [DIST_W-1:0]               acc      [NUM_CLASSES];
  logic [DIST_W-1:0]               acc_next [NUM_CLASSES];
  logic [PAD_W-1:0]                query_pad;
  logic [NUM_CLASSES-1:0][PAD_W-1:0] proto_pad;
  logic [CHUNK_BITS-1:0]           chunk_diff [NUM_CLASSES];
  logic                            last_chunk;
  logic [CLASS_W-1:0]              best_class;
  logic [DIST_W-1:0]               best_dist;

  assign last_chunk = (chunk_cnt == CNT_W'(NUM_CHUNKS - 1));
  assign busy       = (state != IDLE);
  assign out        = (state == DONE);

  // Zero-extending both operands to a whole number of chunks makes the padding
  // bits of the last chunk XOR to 0, so they never reach the popcount.
  always_comb begin : chunk_score
    query_pad = PAD_W'(query);
    for (int c = 0; c < NUM_CLASSES; c++) begin
      proto_pad[c]  = PAD_W'(class_hvs[c]);
      chunk_diff[c] = query_pad[int'(chunk_cnt)*CHUNK_BITS +: CHUNK_BITS]
                    ^ proto_pad[c][int'(chunk_cnt)*CHUNK_BITS +: CHUNK_BITS];
      acc_next[c]   = acc[c];
      for (int b = 0; b < CHUNK_BITS; b++) begin
        acc_next[c] = acc_next[c] + DIST_W'(chunk_diff[c][b]);
      end
    end
  end

  // Strict less-than keeps the lowest class index on a tie.
  always_comb begin : argmin
    best_dist  = acc_next[0];
    best_class = '0;
    for (int c = 1; c < NUM_CLASSES; c++) begin
      if (acc_next[c] < best_dist) begin
        best_dist  = acc_next[c];
        best_class = CLASS_W'(c);
      end
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin : fsm_next
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = COMPARE;
      COMPARE: if (last_chunk) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_next;
  end

  // Results are captured on the final accumulate edge so they are already
  // valid during the DONE cycle that carries the out pulse.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      query     <= '0;
      chunk_cnt <= '0;
      class_out <= '0;
      min_dist  <= '0;
      // NOTE: the accumulator array is a handful of flops, not a RAM, so it
      // is cleared on reset like any other register.
      for (int c = 0; c < NUM_CLASSES; c++) acc[c] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            query     <= hv_in;
            chunk_cnt <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) acc[c] <= '0;
          end
        end
        COMPARE: begin
          for (int c = 0; c < NUM_CLASSES; c++) acc[c] <= acc_next[c];
          if (last_chunk) begin
            class_out <= best_class;
            min_dist  <= best_dist;
          end else begin
            chunk_cnt <= chunk_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef AM_OVERRUN_ERR_EN
  // A start strobe arriving while busy is a dropped bundler result.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)            err <= 1'b0;
    else if (en && busy)  err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_am_search_hf.sv
// Directed self-checking bench for am_search_hf with a 10-bit HV, 4-bit chunks
// (3 chunks, last one partial) and two classes.
module tb_am_search_hf;

  localparam int DIMENSIONS  = 10;
  localparam int NUM_CLASSES = 2;
  localparam int CHUNK_BITS  = 4;
  localparam int NUM_CHUNKS  = 3;

  logic                                   clk;
  logic                                   nrst;
  logic                                   en;
  logic [DIMENSIONS-1:0]                  hv_in;
  logic [NUM_CLASSES-1:0][DIMENSIONS-1:0] class_hvs;
  logic                                   busy;
  logic                                   out;
  logic [0:0]                             class_out;
  logic [3:0]                             min_dist;
`ifdef AM_OVERRUN_ERR_EN
  logic                                   err;
`endif

  int errors = 0;
  int checks = 0;

  am_search_hf #(
    .DIMENSIONS (DIMENSIONS),
    .NUM_CLASSES(NUM_CLASSES),
    .CHUNK_BITS (CHUNK_BITS)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .en       (en),
    .hv_in    (hv_in),
    .class_hvs(class_hvs),
    .busy     (busy),
    .out      (out),
    .class_out(class_out),
    .min_dist (min_dist)
`ifdef AM_OVERRUN_ERR_EN
    ,
    .err      (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepted at edge 0; out is observed after edge NUM_CHUNKS (sampled high at
  // edge NUM_CHUNKS+1), busy covers the whole span, then both drop.
  task automatic run_query(input logic [DIMENSIONS-1:0] hv, input int exp_c,
                           input int exp_d, input string tag);
    int lat;
    en    = 1'b1;
    hv_in = hv;
    tick();
    en    = 1'b0;
    hv_in = ~hv;
    check({tag, "_busy_start"}, busy, 1);
    check({tag, "_out_start"},  out,  0);
    lat = 0;
    while (!out && lat < 10) begin
      tick();
      lat++;
      if (!out) check({tag, "_busy_mid"}, busy, 1);
    end
    check({tag, "_latency"},   lat,       NUM_CHUNKS);
    check({tag, "_out"},       out,       1);
    check({tag, "_busy_out"},  busy,      1);
    check({tag, "_class"},     class_out, exp_c);
    check({tag, "_dist"},      min_dist,  exp_d);
    tick();
    check({tag, "_out_end"},   out,       0);
    check({tag, "_busy_end"},  busy,      0);
    check({tag, "_class_hold"}, class_out, exp_c);
    check({tag, "_dist_hold"},  min_dist,  exp_d);
  endtask

  initial begin
    int pulses;
    logic [31:0] got_c, got_d;

    nrst      = 1'b0;
    en        = 1'b0;
    hv_in     = '0;
    class_hvs[0] = 10'h000;
    class_hvs[1] = 10'h3FF;
    #12;
    check("rst_busy",  busy,      0);
    check("rst_out",   out,       0);
    check("rst_class", class_out, 0);
    check("rst_dist",  min_dist,  0);
`ifdef AM_OVERRUN_ERR_EN
    check("rst_err", err, 0);
`endif
    tick();
    nrst = 1'b1;
    tick();

    // 1..3: basic, opposite class, tie (queries are back-to-back at minimum spacing)
    run_query(10'h007, 0, 3, "basic");
    run_query(10'h3F0, 1, 4, "opposite");
    run_query(10'h01F, 0, 5, "tie");

    // Maximum distance to both prototypes: tie at DIMENSIONS
    class_hvs[1] = 10'h000;
    run_query(10'h3FF, 0, 10, "maxdist");

    // 4: bit 9 lives in the partial last chunk
    class_hvs[1] = 10'h200;
    run_query(10'h200, 1, 0, "partial");
    class_hvs[1] = 10'h3FF;

    // 5: second en two cycles after the first is ignored
    en    = 1'b1;
    hv_in = 10'h007;
    tick();
    hv_in = 10'h3FF;
    en    = 1'b0;
    tick();
    en    = 1'b1;
    tick();
    en    = 1'b0;
`ifdef AM_OVERRUN_ERR_EN
    check("ovr_err_set", err, 1);
`endif
    pulses = 0;
    got_c  = '1;
    got_d  = '1;
    for (int i = 0; i < 10; i++) begin
      if (out) begin
        pulses++;
        got_c = 32'(class_out);
        got_d = 32'(min_dist);
      end
      tick();
    end
    check("ovr_pulses", pulses, 1);
    check("ovr_class",  got_c,  0);
    check("ovr_dist",   got_d,  3);
`ifdef AM_OVERRUN_ERR_EN
    check("ovr_err_sticky", err, 1);
`endif

    // 6: reset during the second COMPARE cycle aborts the search
    en    = 1'b1;
    hv_in = 10'h3F0;
    tick();
    en    = 1'b0;
    tick();
    nrst  = 1'b0;
    #1;
    check("abort_busy",  busy,      0);
    check("abort_out",   out,       0);
    check("abort_class", class_out, 0);
    check("abort_dist",  min_dist,  0);
`ifdef AM_OVERRUN_ERR_EN
    check("abort_err", err, 0);
`endif
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out) pulses++;
    end
    nrst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    check("abort_idle",     busy,   0);
    run_query(10'h3F0, 1, 4, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
